simple_spi_master: RTL and testbench

Configurable SPI bus master that shifts out 8/16/24/32-bit words on MOSI while simultaneously capturing MISO, with run-time selectable clock mode (CPOL/CPHA), SCLK divider and one of eight active-low chip selects. It sits between a local controller, which issues `start_trans` and polls `busy`, and off-chip or on-chip SPI slaves. The SPI clock is generated from the single system clock; no other clock domains exist.

---
 rtl/simple_spi_master.sv | 199 +++++++++++++++++++
 tb/tb_simple_spi_master.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/simple_spi_master.sv
// SPI master: 8/16/24/32-bit words, CPOL/CPHA modes, 2^n SCLK divider, eight active-low selects.
// Define SPI_LSB_FIRST_EN to shift LSB first; the default build shifts MSB first.
module simple_spi_master (
   input  logic        clk,
   input  logic        rst,
   input  logic        start_trans,
   output logic        busy,
   output logic        MOSI,
   input  logic        MISO,
   output logic        SPI_SCLK,
   output logic [7:0]  CS,
   input  logic [31:0] tx_data,
   output logic [31:0] rx_data,
   input  logic [2:0]  chipADDRS,
   input  logic [1:0]  transaction_length,
   input  logic [3:0]  division_ratio,
   input  logic        CPOL,
   input  logic        CPHA,
   input  logic        default_val
);
   typedef enum logic [1:0] {IDLE = 2'd0, READY = 2'd1, TRANSFER = 2'd2, DONE = 2'd3} state_t;

`ifdef SPI_LSB_FIRST_EN
   localparam int TX_POS = 0;
`else
   localparam int TX_POS = 31;
`endif

   state_t      state_r;
   logic        start_r;
   logic [1:0]  len_r;
   logic [3:0]  div_r;
   logic        cpha_r;
   logic        dflt_r;
   logic [15:0] cnt_r;
   logic [6:0]  edge_r;
   logic [31:0] tx_sh_r;
   logic [31:0] rx_sh_r;
   logic        sclk_r;
   logic        mosi_r;
   logic        busy_r;
   logic [7:0]  cs_r;
   logic [31:0] rx_data_r;

   logic [15:0] half_m1_s;
   logic        hp_end_s;
   logic [6:0]  edges_s;
   logic [6:0]  next_edge_s;
   logic        do_sample_s;
   logic        do_drive_s;
   logic [31:0] tx_load_s;

   function automatic logic [4:0] pad_bits(input logic [1:0] len);
      pad_bits = 5'd24 - {len, 3'b000};
   endfunction

   function automatic logic [31:0] align_tx(input logic [31:0] d, input logic [1:0] len);
`ifdef SPI_LSB_FIRST_EN
      align_tx = d & (32'hFFFF_FFFF >> pad_bits(len));
`else
      align_tx = d << pad_bits(len);
`endif
   endfunction

   function automatic logic [31:0] shift_tx(input logic [31:0] sh);
`ifdef SPI_LSB_FIRST_EN
      shift_tx = sh >> 1;
`else
      shift_tx = sh << 1;
`endif
   endfunction

   function automatic logic [31:0] shift_rx(input logic [31:0] sh, input logic b);
`ifdef SPI_LSB_FIRST_EN
      shift_rx = (sh >> 1) | {b, 31'd0};
`else
      shift_rx = (sh << 1) | {31'd0, b};
`endif
   endfunction

   function automatic logic [31:0] extract_rx(input logic [31:0] sh, input logic [1:0] len);
`ifdef SPI_LSB_FIRST_EN
      extract_rx = sh >> pad_bits(len);
`else
      extract_rx = sh & (32'hFFFF_FFFF >> pad_bits(len));
`endif
   endfunction

   // Half-period timing and per-toggle sample/drive decisions (odd toggle = leading edge).
   always_comb begin
      half_m1_s   = (16'd1 << div_r) - 16'd1;
      hp_end_s    = (cnt_r == half_m1_s);
      edges_s     = ({5'd0, len_r} + 7'd1) << 4;
      next_edge_s = edge_r + 7'd1;
      tx_load_s   = align_tx(tx_data, transaction_length);
      if (cpha_r) begin
         do_sample_s = ~next_edge_s[0];
         do_drive_s  = next_edge_s[0];
      end else begin
         do_sample_s = next_edge_s[0];
         do_drive_s  = ~next_edge_s[0] && (next_edge_s != edges_s);
      end
   end

   // Idle levels follow the live CPOL/default_val so reset values track those inputs.
   assign SPI_SCLK = (state_r == IDLE) ? CPOL : sclk_r;
   assign MOSI     = (state_r == IDLE) ? default_val : mosi_r;
   assign busy     = busy_r;
   assign CS       = cs_r;
   assign rx_data  = rx_data_r;

   // Transaction FSM: accept, READY half-period, 2N toggling half-periods, DONE half-period.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r   <= IDLE;
         start_r   <= 1'b0;
         len_r     <= 2'd0;
         div_r     <= 4'd0;
         cpha_r    <= 1'b0;
         dflt_r    <= 1'b0;
         cnt_r     <= 16'd0;
         edge_r    <= 7'd0;
         tx_sh_r   <= 32'd0;
         rx_sh_r   <= 32'd0;
         sclk_r    <= 1'b0;
         mosi_r    <= 1'b0;
         busy_r    <= 1'b0;
         cs_r      <= 8'hFF;
         rx_data_r <= 32'd0;
      end else begin
         start_r <= start_trans;
         case (state_r)
            IDLE: begin
               if (start_trans && !start_r) begin
                  len_r   <= transaction_length;
                  div_r   <= division_ratio;
                  cpha_r  <= CPHA;
                  dflt_r  <= default_val;
                  cnt_r   <= 16'd0;
                  edge_r  <= 7'd0;
                  rx_sh_r <= 32'd0;
                  sclk_r  <= CPOL;
                  busy_r  <= 1'b1;
                  cs_r    <= ~(8'd1 << chipADDRS);
                  state_r <= READY;
                  if (CPHA) begin
                     mosi_r  <= default_val;
                     tx_sh_r <= tx_load_s;
                  end else begin
                     mosi_r  <= tx_load_s[TX_POS];
                     tx_sh_r <= shift_tx(tx_load_s);
                  end
               end else begin
                  busy_r <= 1'b0;
                  cs_r   <= 8'hFF;
               end
            end
            READY, TRANSFER: begin
               if (!hp_end_s) begin
                  cnt_r <= cnt_r + 16'd1;
               end else begin
                  cnt_r <= 16'd0;
                  if (edge_r == edges_s) begin
                     state_r <= DONE;
                     mosi_r  <= dflt_r;
                  end else begin
                     state_r <= TRANSFER;
                     edge_r  <= next_edge_s;
                     sclk_r  <= ~sclk_r;
                     if (do_sample_s) begin
                        rx_sh_r <= shift_rx(rx_sh_r, MISO);
                     end
                     if (do_drive_s) begin
                        mosi_r  <= tx_sh_r[TX_POS];
                        tx_sh_r <= shift_tx(tx_sh_r);
                     end
                  end
               end
            end
            DONE: begin
               if (!hp_end_s) begin
                  cnt_r <= cnt_r + 16'd1;
               end else begin
                  cnt_r     <= 16'd0;
                  rx_data_r <= extract_rx(rx_sh_r, len_r);
                  cs_r      <= 8'hFF;
                  busy_r    <= 1'b0;
                  state_r   <= IDLE;
               end
            end
            default: begin
               state_r <= IDLE;
               busy_r  <= 1'b0;
               cs_r    <= 8'hFF;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_simple_spi_master.sv
// Scoreboard bench for simple_spi_master: behavioural SPI slave, randomized and directed transactions.
module tb_simple_spi_master;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start_trans = 1'b0;
   logic        busy, MOSI, MISO, SPI_SCLK;
   logic [7:0]  CS;
   logic [31:0] tx_data = 32'd0;
   logic [31:0] rx_data;
   logic [2:0]  chipADDRS = 3'd0;
   logic [1:0]  transaction_length = 2'd0;
   logic [3:0]  division_ratio = 4'd0;
   logic        CPOL = 1'b1;
   logic        CPHA = 1'b0;
   logic        default_val = 1'b1;

   always #5 clk = ~clk;

   simple_spi_master dut (
      .clk(clk), .rst(rst), .start_trans(start_trans), .busy(busy), .MOSI(MOSI), .MISO(MISO),
      .SPI_SCLK(SPI_SCLK), .CS(CS), .tx_data(tx_data), .rx_data(rx_data), .chipADDRS(chipADDRS),
      .transaction_length(transaction_length), .division_ratio(division_ratio), .CPOL(CPOL),
      .CPHA(CPHA), .default_val(default_val)
   );

   typedef struct {
      logic [31:0] rx;
      logic [31:0] srx;
      int          cycles;
      logic [7:0]  cs;
      int          toggles;
   } exp_t;

   exp_t sb_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   n_done  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural SPI slave: mode-aware, shifts its word out and records what it receives.
   logic        s_cpol = 1'b0, s_cpha = 1'b0, s_loop = 1'b0, miso_s = 1'b0;
   int          s_n = 8, s_sent = 0, s_got = 0;
   logic [31:0] s_word = 32'd0, s_rx = 32'd0;
   logic        cs_act;
   assign cs_act = (CS != 8'hFF);
   assign MISO   = s_loop ? MOSI : miso_s;

   function automatic int bit_pos(input int k, input int n);
`ifdef SPI_LSB_FIRST_EN
      return k;
`else
      return n - 1 - k;
`endif
   endfunction

   task automatic slave_drive();
      if (s_sent < s_n) begin
         miso_s = s_word[bit_pos(s_sent, s_n)];
         s_sent++;
      end
   endtask

   always @(posedge cs_act) begin
      s_sent = 0;
      s_got  = 0;
      s_rx   = 32'd0;
      if (!s_cpha) slave_drive();
   end

   always @(SPI_SCLK) begin
      if (cs_act === 1'b1) begin
         if ((SPI_SCLK != s_cpol) ^ s_cpha) begin
            if (s_got < s_n) begin
               s_rx[bit_pos(s_got, s_n)] = MOSI;
               s_got++;
            end
         end else begin
            slave_drive();
         end
      end
   end

   // Monitor: measures each busy window and compares against the scoreboard on busy fall.
   logic        in_busy = 1'b0, cs_bad = 1'b0, sclk_prev = 1'b0;
   int          bcnt = 0, tog = 0;
   logic [7:0]  cs_seen = 8'hFF;
   logic [31:0] m_last_rx = 32'd0;
   exp_t        mon_e;

   always @(negedge clk) begin
      if (rst) begin
         in_busy   = 1'b0;
         m_last_rx = 32'd0;
      end else if (busy) begin
         if (!in_busy) begin
            in_busy = 1'b1;
            bcnt = 0; tog = 0; cs_seen = CS; cs_bad = 1'b0;
            check("rx_hold", rx_data, m_last_rx);
         end
         bcnt++;
         if (CS !== cs_seen) cs_bad = 1'b1;
         if (SPI_SCLK !== sclk_prev) tog++;
      end else if (in_busy) begin
         in_busy = 1'b0;
         n_done++;
         if (sb_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL unexpected_trans: got a transaction, expected none at %0t", $time);
         end else begin
            mon_e = sb_q.pop_front();
            check("rx_data", rx_data, mon_e.rx);
            check("slave_rx", s_rx, mon_e.srx);
            check("busy_cycles", bcnt, mon_e.cycles);
            check("cs_value", {24'd0, cs_seen}, {24'd0, mon_e.cs});
            check("cs_stable", {31'd0, cs_bad}, 32'd0);
            check("sclk_toggles", tog, mon_e.toggles);
            m_last_rx = mon_e.rx;
         end
      end
      sclk_prev = SPI_SCLK;
   end

   task automatic run(input logic [31:0] tx, input logic [31:0] sw, input int len, input int div,
                      input logic cpol, input logic cpha, input int addr, input logic dflt,
                      input logic loop, input int hold);
      exp_t        e;
      int          n, h, c;
      logic        seen;
      logic [31:0] mask;
      @(posedge clk); #1;
      n = 8 * (len + 1);
      h = 1 << div;
      mask = (n == 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
      tx_data = tx; transaction_length = len[1:0]; division_ratio = div[3:0];
      CPOL = cpol; CPHA = cpha; chipADDRS = addr[2:0]; default_val = dflt;
      s_cpol = cpol; s_cpha = cpha; s_n = n; s_word = sw; s_loop = loop;
      #1;
      check("idle_sclk", {31'd0, SPI_SCLK}, {31'd0, cpol});
      check("idle_mosi", {31'd0, MOSI}, {31'd0, dflt});
      e.rx = (loop ? tx : sw) & mask;
      e.srx = tx & mask;
      e.cycles = (2 * n + 2) * h;
      e.cs = ~(8'd1 << addr);
      e.toggles = 2 * n;
      sb_q.push_back(e);
      start_trans = 1'b1;
      c = 0;
      seen = 1'b0;
      while (c < e.cycles + 20 && !(seen && !busy)) begin
         @(posedge clk); #1;
         c++;
         if (c >= hold) start_trans = 1'b0;
         if (busy && !seen) begin
            seen = 1'b1;
            tx_data = $urandom; chipADDRS = 3'($urandom); transaction_length = 2'($urandom);
            division_ratio = 4'($urandom); CPOL = 1'($urandom); CPHA = 1'($urandom);
            default_val = 1'($urandom);
         end
      end
      check("accepted", {31'd0, seen}, 32'd1);
      check("ended", {31'd0, busy}, 32'd0);
      @(posedge clk); #1;
   endtask

   int base;

   initial begin
      #1 rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_cs", {24'd0, CS}, 32'h0000_00FF);
      check("rst_rx", rx_data, 32'd0);
      check("rst_sclk", {31'd0, SPI_SCLK}, 32'd1);
      check("rst_mosi", {31'd0, MOSI}, 32'd1);
      rst = 1'b0;
      repeat (2) @(posedge clk);

      run(32'h0000_00AA, 32'h0000_00FB, 0, 1, 1'b0, 1'b1, 0, 1'b0, 1'b0, 1);
      run(32'hC926_A05C, 32'hF976_32D4, 3, 1, 1'b0, 1'b0, 2, 1'b1, 1'b0, 1);
      for (int m = 0; m < 4; m++)
         run(32'h0000_ACD9, 32'h0000_5D6A, 1, 1, m[1], m[0], 3, m[0], 1'b0, 1);
      run(32'h0000_003C, 32'h0000_0000, 0, 0, 1'b0, 1'b0, 5, 1'b0, 1'b1, 1);

      base = n_done;
      run(32'h0000_0081, 32'h0000_0042, 0, 0, 1'b0, 1'b0, 7, 1'b1, 1'b0, 20);
      repeat (25) @(posedge clk);
      #1 start_trans = 1'b0;
      repeat (30) @(posedge clk);
      #1;
      check("single_trans", n_done - base, 32'd1);
      check("idle_mosi_dflt1", {31'd0, MOSI}, 32'd1);

      // Abort a 32-bit transfer with reset.
      tx_data = 32'hDEAD_BEEF; transaction_length = 2'd3; division_ratio = 4'd1;
      chipADDRS = 3'd1; CPOL = 1'b0; CPHA = 1'b0; s_cpol = 1'b0; s_cpha = 1'b0; s_loop = 1'b0;
      s_n = 32; s_word = 32'h1234_5678;
      start_trans = 1'b1;
      repeat (3) @(posedge clk);
      #1 start_trans = 1'b0;
      check("abort_started", {31'd0, busy}, 32'd1);
      repeat (40) @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_cs", {24'd0, CS}, 32'h0000_00FF);
      check("abort_rx", rx_data, 32'd0);
      @(posedge clk); #1 rst = 1'b0;
      repeat (2) @(posedge clk);
      run(32'h0000_5A5A, 32'h0000_C3A5, 1, 0, 1'b1, 1'b1, 4, 1'b0, 1'b0, 1);

      for (int i = 0; i < 16; i++)
         run($urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 2), 1'($urandom),
             1'($urandom), $urandom_range(0, 7), 1'($urandom), ($urandom_range(0, 3) == 0), 1);

      repeat (5) @(posedge clk);
      check("scoreboard_drained", sb_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog expired");
   end
endmodule
